// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT scheduler: state encoding, default size, bit reversal.
package fft_pkg;

  localparam int FFT_LOG2N_DEFAULT = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_BF   = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_URD  = 3'd5;
  localparam logic [2:0] ST_UOUT = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RD   = ST_RD,
    S_BF   = ST_BF,
    S_WB   = ST_WB,
    S_URD  = ST_URD,
    S_UOUT = ST_UOUT,
    S_DONE = ST_DONE
  } fft_state_e;

  // Reverse the low n bits of v; bits at and above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < int'(n)) r[i] = v[int'(n) - 1 - i];
    return r;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Registered butterfly address generator: pair addresses and twiddle index for stage s, butterfly j.
module fft_agu
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N_DEFAULT,
  parameter int SW    = $clog2(LOG2N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  logic [LOG2N-1:0] jw, half, k, a;
  logic [SW-1:0]    s1, tsh;

  always_comb begin
    jw   = {1'b0, j};
    half = LOG2N'(1) << s;
    k    = jw & (half - LOG2N'(1));
    s1   = s + SW'(1);
    a    = ((jw >> s) << s1) | k;
    tsh  = SW'(LOG2N - 1) - s;
  end

  // k < half <= N/2, so it always fits the narrower twiddle width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a  <= '0;
      addr_b  <= '0;
      tw_addr <= '0;
    end else begin
      addr_a  <= a;
      addr_b  <= a + half;
      tw_addr <= k[LOG2N-2:0] << tsh;
    end
  end

endmodule

// File: rtl/fft_r2_scheduler.sv
// In-place radix-2 DIT FFT scheduler: load, LOG2N butterfly stages, unload over one BRAM.
// Define FFT_BITREV_EN to bit-reverse load addresses so samples enter in natural order.
module fft_r2_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N_DEFAULT,
  parameter int BF_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           src_sel_o,
  output logic                           mem_rd_en_o,
  output logic                           mem_we_o,
  output logic [LOG2N-1:0]               mem_addr_a_o,
  output logic [LOG2N-1:0]               mem_addr_b_o,
  output logic                           bf_ce_o,
  output logic [LOG2N-2:0]               tw_addr_o,
  output logic [$clog2(LOG2N+1)-1:0]     stage_o
);

  localparam int SW = $clog2(LOG2N + 1);
  localparam logic [LOG2N-1:0] IDX_LAST = '1;
  localparam logic [LOG2N-2:0] J_LAST   = '1;
  localparam logic [SW-1:0]    S_LAST   = SW'(LOG2N - 1);
  localparam logic [2:0]       BF_LAST  = 3'(BF_LAT - 1);

  fft_state_e       state;
  logic [LOG2N-1:0] idx, laddr;
  logic [LOG2N-2:0] j, agu_j;
  logic [SW-1:0]    s, agu_s;
  logic [2:0]       bf_cnt;
  logic [LOG2N-1:0] agu_a, agu_b;
  logic [LOG2N-2:0] agu_tw;

`ifdef FFT_BITREV_EN
  assign laddr = LOG2N'(bitrev(32'(idx), LOG2N));
`else
  assign laddr = idx;
`endif

  // The AGU is registered, so it is fed the pair the next RD will use
  always_comb begin
    agu_s = s;
    agu_j = j;
    if (state == S_LOAD) begin
      agu_s = '0;
      agu_j = '0;
    end else if (state == S_WB) begin
      if (j != J_LAST) begin
        agu_j = j + 1'b1;
      end else if (s != S_LAST) begin
        agu_s = s + SW'(1);
        agu_j = '0;
      end
    end
  end

  fft_agu #(.LOG2N(LOG2N), .SW(SW)) u_agu (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (agu_s),
    .j       (agu_j),
    .addr_a  (agu_a),
    .addr_b  (agu_b),
    .tw_addr (agu_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      j      <= '0;
      s      <= '0;
      bf_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          state <= S_LOAD;
          idx   <= '0;
        end
        S_LOAD: if (in_valid_i) begin
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state <= S_RD;
            s     <= '0;
            j     <= '0;
          end
        end
        S_RD: begin
          state  <= S_BF;
          bf_cnt <= '0;
        end
        S_BF: begin
          if (bf_cnt == BF_LAST) state <= S_WB;
          else                   bf_cnt <= bf_cnt + 3'd1;
        end
        S_WB: begin
          if (j != J_LAST) begin
            j     <= j + 1'b1;
            state <= S_RD;
          end else if (s != S_LAST) begin
            s     <= s + SW'(1);
            j     <= '0;
            state <= S_RD;
          end else begin
            idx   <= '0;
            state <= S_URD;
          end
        end
        S_URD: state <= S_UOUT;
        S_UOUT: if (out_ready_i) begin
          if (idx == IDX_LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_URD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign in_ready_o  = (state == S_LOAD);
  assign out_valid_o = (state == S_UOUT);
  assign src_sel_o   = (state == S_WB);
  assign bf_ce_o     = (state == S_BF);
  assign mem_rd_en_o = (state == S_RD) || (state == S_URD);
  assign mem_we_o    = ((state == S_LOAD) && in_valid_i) || (state == S_WB);
  assign stage_o     = s;

  always_comb begin
    mem_addr_a_o = '0;
    mem_addr_b_o = '0;
    tw_addr_o    = '0;
    case (state)
      S_LOAD:         mem_addr_a_o = laddr;
      S_URD, S_UOUT:  mem_addr_a_o = idx;
      S_RD, S_BF, S_WB: begin
        mem_addr_a_o = agu_a;
        mem_addr_b_o = agu_b;
        tw_addr_o    = agu_tw;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_r2_scheduler.sv
// Directed bench for fft_r2_scheduler at LOG2N=3 (BF_LAT=2 main instance, BF_LAT=5 second instance).
module tb_fft_r2_scheduler;

  logic clk = 1'b0;
  logic rst_n, start_i, start5, in_valid_i, out_ready_i;

  logic       busy_o, done_o, in_ready_o, out_valid_o, src_sel_o, mem_rd_en_o, mem_we_o, bf_ce_o;
  logic [2:0] mem_addr_a_o, mem_addr_b_o;
  logic [1:0] tw_addr_o, stage_o;

  logic       busy5, done5, in_ready5, out_valid5, src_sel5, rd_en5, we5, bf_ce5;
  logic [2:0] addr_a5, addr_b5;
  logic [1:0] tw5, stage5;

  int n_run  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

  fft_r2_scheduler #(.LOG2N(3), .BF_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .src_sel_o(src_sel_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_we_o(mem_we_o), .mem_addr_a_o(mem_addr_a_o), .mem_addr_b_o(mem_addr_b_o),
    .bf_ce_o(bf_ce_o), .tw_addr_o(tw_addr_o), .stage_o(stage_o)
  );

  fft_r2_scheduler #(.LOG2N(3), .BF_LAT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(start5), .busy_o(busy5), .done_o(done5),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready5), .out_valid_o(out_valid5),
    .out_ready_i(out_ready_i), .src_sel_o(src_sel5), .mem_rd_en_o(rd_en5),
    .mem_we_o(we5), .mem_addr_a_o(addr_a5), .mem_addr_b_o(addr_b5),
    .bf_ce_o(bf_ce5), .tw_addr_o(tw5), .stage_o(stage5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef FFT_BITREV_EN
  int exp_w[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int exp_w[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // Pulse start on the chosen instance and stream 8 samples; leaves that instance in RD.
  task automatic do_load(input bit use5, input bit check);
    if (use5) start5 = 1'b1; else start_i = 1'b1;
    tick();
    start_i = 1'b0;
    start5  = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (check) begin
        chk("load_ready", 32'(in_ready_o), 1);
        chk("load_we", 32'(mem_we_o), 1);
        chk("load_src", 32'(src_sel_o), 0);
        chk("load_addr", 32'(mem_addr_a_o), 32'(exp_w[i]));
      end
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  initial begin
    int  ce_cnt;
    bit  seen;
    int  done_before;
    rst_n = 1'b0; start_i = 1'b0; start5 = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_ready", 32'(in_ready_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr_a", 32'(mem_addr_a_o), 0);
    chk("rst_stage", 32'(stage_o), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Idle ignores in_valid
    in_valid_i = 1'b1;
    @(negedge clk);
    chk("idle_we", 32'(mem_we_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    tick();
    in_valid_i = 1'b0;

    do_load(1'b0, 1'b1);
    start_i = 1'b1;  // must be ignored during compute

    // Compute: 12 butterflies of RD, 2xBF, WB
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk("rd_en", 32'(mem_rd_en_o), 1);
      chk("rd_addr_a", 32'(mem_addr_a_o), 32'(exp_a[t]));
      chk("rd_addr_b", 32'(mem_addr_b_o), 32'(exp_b[t]));
      chk("rd_tw", 32'(tw_addr_o), 32'(exp_tw[t]));
      chk("rd_stage", 32'(stage_o), 32'(t / 4));
      chk("rd_ce", 32'(bf_ce_o), 0);
      tick();
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        chk("bf_ce", 32'(bf_ce_o), 1);
        chk("bf_hold_a", 32'(mem_addr_a_o), 32'(exp_a[t]));
        chk("bf_we", 32'(mem_we_o), 0);
        tick();
      end
      start_i = 1'b0;
      @(negedge clk);
      chk("wb_we", 32'(mem_we_o), 1);
      chk("wb_src", 32'(src_sel_o), 1);
      chk("wb_addr_b", 32'(mem_addr_b_o), 32'(exp_b[t]));
      tick();
    end

    // Unload with a stalled handshake on word 3
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      chk("urd_en", 32'(mem_rd_en_o), 1);
      chk("urd_addr", 32'(mem_addr_a_o), 32'(w));
      chk("urd_valid", 32'(out_valid_o), 0);
      out_ready_i = (w == 3) ? 1'b0 : 1'b1;
      tick();
      if (w == 3) begin
        for (int h = 0; h < 2; h++) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid_o), 1);
          chk("stall_addr", 32'(mem_addr_a_o), 3);
          chk("stall_rd", 32'(mem_rd_en_o), 0);
          tick();
        end
        out_ready_i = 1'b1;
      end
      @(negedge clk);
      chk("uout_valid", 32'(out_valid_o), 1);
      chk("uout_addr", 32'(mem_addr_a_o), 32'(w));
      chk("uout_done", 32'(done_o), 0);
      tick();
    end
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 1);
    chk("done_busy", 32'(busy_o), 1);
    tick();
    @(negedge clk);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_busy2", 32'(busy_o), 0);
    chk("done_count", 32'(done_cnt), 1);
    tick();

    // Reset in the middle of a BF phase (stage 0, butterfly 1)
    do_load(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    chk("pre_rst_ce", 32'(bf_ce_o), 1);
    chk("pre_rst_addr", 32'(mem_addr_a_o), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_ce", 32'(bf_ce_o), 0);
    chk("arst_addr_a", 32'(mem_addr_a_o), 0);
    chk("arst_addr_b", 32'(mem_addr_b_o), 0);
    chk("arst_tw", 32'(tw_addr_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_done", 32'(done_cnt), 1);

    // Fresh run completes
    done_before = done_cnt;
    do_load(1'b0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      tick();
    end
    chk("rerun_done", 32'(seen), 1);
    chk("rerun_count", 32'(done_cnt), 32'(done_before + 1));

    // BF_LAT=5 instance: first butterfly spans 7 cycles
    do_load(1'b1, 1'b0);
    ce_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 7 && bf_ce5) ce_cnt++;
      if (c == 0) begin
        chk("l5_rd0", 32'(rd_en5), 1);
        chk("l5_a0", 32'(addr_a5), 0);
      end
      if (c == 6) chk("l5_we", 32'(we5), 1);
      if (c == 7) begin
        chk("l5_rd1", 32'(rd_en5), 1);
        chk("l5_a1", 32'(addr_a5), 2);
      end
      tick();
    end
    chk("l5_ce_cycles", 32'(ce_cnt), 5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
